// File: rtl/tag_reclaim_if.sv
// Release-side and free-list-side signals of the tag reclaim stage.
// The slave modport is the reclaim block; the master modport is its environment.
interface tag_reclaim_if #(
  parameter int IN   = 4,
  parameter int OUT  = 4,
  parameter int DATA = 16,
  parameter int CW   = 5
);
  logic                      flush_;
  logic [IN-1:0]             rel_;
  logic [IN-1:0][DATA-1:0]   rel_tag;
  logic                      full;
  logic                      ovf;
  logic [CW-1:0]             cnt;
  logic [OUT-1:0]            fl_we_;
  logic [OUT-1:0][DATA-1:0]  fl_wd;
  logic                      fl_busy;

  modport master (
    output flush_, rel_, rel_tag, fl_busy,
    input  full, ovf, cnt, fl_we_, fl_wd
  );

  modport slave (
    input  flush_, rel_, rel_tag, fl_busy,
    output full, ovf, cnt, fl_we_, fl_wd
  );
endinterface

// File: rtl/tag_reclaim.sv
// Collects released tags into a circular queue and drains them to the free list.
// Optional same-cycle bypass to the free list: define TAG_RECLAIM_BYPASS_EN.
module tag_reclaim #(
  parameter int DEPTH   = 16,
  parameter int IN      = 4,
  parameter int OUT     = 4,
  parameter int QDEPTH  = 16,
  parameter int BIT_VEC = 1,
  localparam int DATA   = BIT_VEC ? DEPTH : $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  tag_reclaim_if.slave  rif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [DATA-1:0]           mem [QDEPTH];
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;
  logic [CW-1:0]             cnt_q;
  logic                      ovf_q;

  logic [CW-1:0]             slot [IN];
  logic [CW-1:0]             nin;
  logic [CW-1:0]             nout_avail;
  logic [CW-1:0]             npop;
  logic [CW-1:0]             nbyp;
  logic [CW-1:0]             nenq;
  logic                      full_c;
  logic                      rel_any;
  logic                      rel_ok;
  logic [IN-1:0]             wr_en;
  logic [PW-1:0]             wr_idx [IN];
  logic [OUT-1:0]            we_c;
  logic [OUT-1:0][DATA-1:0]  wd_c;
`ifdef TAG_RECLAIM_BYPASS_EN
  logic                      byp_ok;
`endif

  // Rank of each active port among the active ports gives its compacted slot.
  always_comb begin
    nin = '0;
    for (int i = 0; i < IN; i++) begin
      slot[i] = nin;
      if (!rif.rel_[i]) nin = nin + CW'(1);
    end
    rel_any = ~&rif.rel_;
  end

  always_comb begin
    full_c     = cnt_q > CW'(QDEPTH - IN);
    nout_avail = (cnt_q > CW'(OUT)) ? CW'(OUT) : cnt_q;
    npop       = rif.fl_busy ? '0 : nout_avail;
    rel_ok     = rif.flush_ && !full_c;
`ifdef TAG_RECLAIM_BYPASS_EN
    byp_ok     = rif.flush_ && !rif.fl_busy && (cnt_q == '0) && !full_c;
    nbyp       = byp_ok ? ((nin > CW'(OUT)) ? CW'(OUT) : nin) : '0;
`else
    nbyp       = '0;
`endif
    nenq       = rel_ok ? (nin - nbyp) : '0;
  end

  // Bypassed releases occupy the lowest slots, so the queued ones shift down by nbyp.
  always_comb begin
    for (int i = 0; i < IN; i++) begin
      wr_en[i]  = rel_ok && !rif.rel_[i] && (slot[i] >= nbyp);
      wr_idx[i] = tail + PW'(slot[i] - nbyp);
    end
  end

  always_comb begin
    we_c = '1;
    wd_c = '0;
    for (int k = 0; k < OUT; k++) begin
      if (CW'(k) < nout_avail) begin
        we_c[k] = 1'b0;
        wd_c[k] = mem[head + PW'(k)];
      end
    end
`ifdef TAG_RECLAIM_BYPASS_EN
    // Only reachable with an empty queue, so it never collides with queued entries.
    for (int k = 0; k < OUT; k++) begin
      for (int i = 0; i < IN; i++) begin
        if (byp_ok && !rif.rel_[i] && (slot[i] == CW'(k))) begin
          we_c[k] = 1'b0;
          wd_c[k] = rif.rel_tag[i];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= rif.rel_tag[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (!rif.flush_) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      head  <= head + PW'(npop);
      tail  <= tail + PW'(nenq);
      cnt_q <= cnt_q + nenq - npop;
      if (rel_any && full_c) ovf_q <= 1'b1;
    end
  end

  assign rif.full   = full_c;
  assign rif.ovf    = ovf_q;
  assign rif.cnt    = cnt_q;
  assign rif.fl_we_ = we_c;
  assign rif.fl_wd  = wd_c;

endmodule

// File: tb/tb_tag_reclaim.sv
// Scoreboard bench for tag_reclaim: an ordered queue of expected tags is
// consumed by a negedge monitor that checks fl_*, cnt, full and ovf.
module tb_tag_reclaim;
  localparam int IN   = 4;
  localparam int OUT  = 4;
  localparam int QD   = 16;
  localparam int DATA = 16;
  localparam int CW   = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tag_reclaim_if #(.IN(IN), .OUT(OUT), .DATA(DATA), .CW(CW)) ifc ();

  tag_reclaim #(
    .DEPTH(16), .IN(IN), .OUT(OUT), .QDEPTH(QD), .BIT_VEC(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rif   (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DATA-1:0] expq[$];
  logic [DATA-1:0] pendTags[$];
  bit  mOvf       = 1'b0;
  bit  pendFlush  = 1'b0;
  bit  pendDrop   = 1'b0;
  int  bypPending = 0;
  bit  monEn      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IN-1:0][DATA-1:0] randTags();
    logic [IN-1:0][DATA-1:0] t;
    for (int i = 0; i < IN; i++) t[i] = 16'h0001 << $urandom_range(0, 15);
    return t;
  endfunction

  // Drive one cycle of inputs and work out what the spec says happens to them.
  task automatic driveCycle(input logic [IN-1:0] rel, input logic [IN-1:0][DATA-1:0] tags,
                            input logic busy, input logic fl);
    bit mFull;
    ifc.rel_    = rel;
    ifc.rel_tag = tags;
    ifc.fl_busy = busy;
    ifc.flush_  = fl;
    pendTags.delete();
    for (int i = 0; i < IN; i++) if (!rel[i]) pendTags.push_back(tags[i]);
    mFull     = expq.size() > QD - IN;
    pendFlush = !fl;
    pendDrop  = fl && mFull && (pendTags.size() > 0);
`ifdef TAG_RECLAIM_BYPASS_EN
    if (fl && !busy && expq.size() == 0) begin
      while (pendTags.size() > 0 && bypPending < OUT) begin
        expq.push_back(pendTags.pop_front());
        bypPending++;
      end
    end
`endif
  endtask

  task automatic endCycle();
    @(posedge clk);
    if (pendFlush) begin
      expq.delete();
      mOvf = 1'b0;
    end else if (pendDrop) begin
      mOvf = 1'b1;
    end else begin
      while (pendTags.size() > 0) expq.push_back(pendTags.pop_front());
    end
    pendTags.delete();
    bypPending = 0;
    #1;
  endtask

  task automatic applyStimulus(input logic [IN-1:0] rel, input logic [IN-1:0][DATA-1:0] tags,
                               input logic busy, input logic fl);
    driveCycle(rel, tags, busy, fl);
    endCycle();
  endtask

  task automatic doReset();
    ifc.rel_    = '1;
    ifc.flush_  = 1'b1;
    ifc.fl_busy = 1'b0;
    reset       = 1'b1;
    expq.delete();
    pendTags.delete();
    mOvf       = 1'b0;
    bypPending = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    int ec;
    int np;
    if (monEn && !reset) begin
      ec = expq.size() - bypPending;
      np = (expq.size() < OUT) ? expq.size() : OUT;
      checkOutput("mon_cnt", 32'(ifc.cnt), 32'(ec));
      checkOutput("mon_full", 32'(ifc.full), 32'(ec > QD - IN));
      checkOutput("mon_ovf", 32'(ifc.ovf), 32'(mOvf));
      for (int k = 0; k < OUT; k++) begin
        if (k < np) begin
          checkOutput($sformatf("mon_we%0d", k), 32'(ifc.fl_we_[k]), 32'd0);
          checkOutput($sformatf("mon_wd%0d", k), 32'(ifc.fl_wd[k]), 32'(expq[k]));
        end else begin
          checkOutput($sformatf("mon_we%0d", k), 32'(ifc.fl_we_[k]), 32'd1);
          checkOutput($sformatf("mon_wd%0d", k), 32'(ifc.fl_wd[k]), 32'd0);
        end
      end
      if (!ifc.fl_busy) repeat (np) void'(expq.pop_front());
    end
  end

  initial begin
    logic [IN-1:0][DATA-1:0] t;
    logic [IN-1:0] rel;
    int issued;
    ifc.flush_  = 1'b1;
    ifc.rel_    = '1;
    ifc.rel_tag = '0;
    ifc.fl_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    monEn = 1'b1;

    $display("[TB] reset with tags queued");
    t = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
    applyStimulus(4'b0000, t, 1'b1, 1'b1);
    t = {16'h0000, 16'h0000, 16'h0000, 16'h0010};
    applyStimulus(4'b1110, t, 1'b1, 1'b1);
    checkOutput("pre_rst_cnt", 32'(ifc.cnt), 32'd5);
    doReset();
    checkOutput("rst_cnt", 32'(ifc.cnt), 32'd0);
    checkOutput("rst_we", 32'(ifc.fl_we_), 32'hf);
    checkOutput("rst_full", 32'(ifc.full), 32'd0);
    checkOutput("rst_ovf", 32'(ifc.ovf), 32'd0);

    $display("[TB] compaction");
    t = '0;
    t[1] = 16'h0002;
    t[3] = 16'h0008;
`ifdef TAG_RECLAIM_BYPASS_EN
    driveCycle(4'b0101, t, 1'b0, 1'b1);
    #1;
    checkOutput("cmp_we", 32'(ifc.fl_we_), 32'hc);
    checkOutput("cmp_wd0", 32'(ifc.fl_wd[0]), 32'h2);
    checkOutput("cmp_wd1", 32'(ifc.fl_wd[1]), 32'h8);
    endCycle();
`else
    applyStimulus(4'b0101, t, 1'b0, 1'b1);
    checkOutput("cmp_we", 32'(ifc.fl_we_), 32'hc);
    checkOutput("cmp_wd0", 32'(ifc.fl_wd[0]), 32'h2);
    checkOutput("cmp_wd1", 32'(ifc.fl_wd[1]), 32'h8);
    applyStimulus(4'b1111, t, 1'b0, 1'b1);
`endif
    checkOutput("cmp_cnt", 32'(ifc.cnt), 32'd0);

    $display("[TB] busy hold");
    applyStimulus(4'b0000, randTags(), 1'b1, 1'b1);
    applyStimulus(4'b0011, randTags(), 1'b1, 1'b1);
    repeat (3) applyStimulus(4'b1111, t, 1'b1, 1'b1);
    checkOutput("hold_cnt", 32'(ifc.cnt), 32'd6);
    applyStimulus(4'b1111, t, 1'b0, 1'b1);
    checkOutput("hold_cnt2", 32'(ifc.cnt), 32'd2);
    applyStimulus(4'b1111, t, 1'b0, 1'b1);
    checkOutput("hold_cnt0", 32'(ifc.cnt), 32'd0);

    $display("[TB] wrap and concurrency");
    issued = 0;
    for (int c = 0; c < 100 && issued < 40; c++) begin
      if (expq.size() <= QD - IN) begin
        applyStimulus(4'b0000, randTags(), c[0], 1'b1);
        issued += 4;
      end else begin
        applyStimulus(4'b1111, t, c[0], 1'b1);
      end
    end
    checkOutput("wrap_issued", 32'(issued), 32'd40);
    for (int c = 0; c < 20 && expq.size() > 0; c++) applyStimulus(4'b1111, t, 1'b0, 1'b1);
    checkOutput("wrap_drained", 32'(ifc.cnt), 32'd0);

    $display("[TB] overflow and flush");
    applyStimulus(4'b0000, randTags(), 1'b1, 1'b1);
    applyStimulus(4'b0000, randTags(), 1'b1, 1'b1);
    applyStimulus(4'b0000, randTags(), 1'b1, 1'b1);
    applyStimulus(4'b1110, randTags(), 1'b1, 1'b1);
    checkOutput("ovf_fill_cnt", 32'(ifc.cnt), 32'd13);
    checkOutput("ovf_fill_full", 32'(ifc.full), 32'd1);
    applyStimulus(4'b0000, randTags(), 1'b1, 1'b1);
    checkOutput("ovf_cnt", 32'(ifc.cnt), 32'd13);
    checkOutput("ovf_flag", 32'(ifc.ovf), 32'd1);
    applyStimulus(4'b1111, t, 1'b1, 1'b0);
    checkOutput("flush_cnt", 32'(ifc.cnt), 32'd0);
    checkOutput("flush_ovf", 32'(ifc.ovf), 32'd0);

    $display("[TB] bypass latency");
    t = '0;
    t[0] = 16'h0010;
`ifdef TAG_RECLAIM_BYPASS_EN
    driveCycle(4'b1110, t, 1'b0, 1'b1);
    #1;
    checkOutput("byp_we0", 32'(ifc.fl_we_[0]), 32'd0);
    checkOutput("byp_wd0", 32'(ifc.fl_wd[0]), 32'h10);
    endCycle();
    checkOutput("byp_cnt", 32'(ifc.cnt), 32'd0);
`else
    applyStimulus(4'b1110, t, 1'b0, 1'b1);
    checkOutput("byp_we0", 32'(ifc.fl_we_[0]), 32'd0);
    checkOutput("byp_wd0", 32'(ifc.fl_wd[0]), 32'h10);
    checkOutput("byp_cnt", 32'(ifc.cnt), 32'd1);
`endif
    applyStimulus(4'b1111, t, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      rel = 4'($urandom);
      if (expq.size() > QD - IN && $urandom_range(0, 7) != 0) rel = '1;
      if (c == 200) doReset();
      applyStimulus(rel, randTags(), ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) != 0));
    end
    for (int c = 0; c < 20 && expq.size() > 0; c++) applyStimulus(4'b1111, t, 1'b0, 1'b1);
    checkOutput("final_cnt", 32'(ifc.cnt), 32'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
